ro_request_sequencer: RTL
=========================

Name: ro_request_sequencer

Overview:
- Schedules readout of the L0 buffer between two requester classes: L1 (normal trigger readout) and R3 (regional fast readout).
- Queues each request's L0ID and picks one at a time, R3 with priority and an L1 starvation guard.
- For each pick it drives the single-cycle ROReadStrob and the RO address, then waits for the readout datapath to finish before issuing the next.
- Sits between the L0/L1 command decoder and the readout/L0ID-local logic. That logic takes one ROReadStrob per readout and needs at least 4 BC between strobes.

Parameters:
RO_ADDR_WIDTH, 8, width of L0ID / readout address
FIFO_DEPTH, 4, entries per request queue (power of 2, >=2)
MIN_GAP, 4, minimum clock cycles from one ROReadStrob to the next (>=4)
R3_MAX_RUN, 3, max consecutive R3 grants while an L1 request waits
DONE_TIMEOUT, 255, cycles in WAIT_DONE before forced abort (8-bit counter)

Ports:
CLK  in  1  bunch-crossing clock
SoftResetB  in  1  synchronous active-low reset
L1Req  in  1  single-cycle L1 readout request
L1ID  in  RO_ADDR_WIDTH  L0ID for L1Req
R3Req  in  1  single-cycle R3 readout request
R3ID  in  RO_ADDR_WIDTH  L0ID for R3Req
RODone  in  1  readout datapath finished current event (pulse)
ClearFlags  in  1  clears sticky overflow/timeout flags
ROReadStrob  out  1  one-cycle readout start
ROAddr  out  RO_ADDR_WIDTH  address of current/last readout
ROIsR3  out  1  current readout is R3 class
ROBusy  out  1  high from strobe until readout complete
L1Full  out  1  L1 queue full
R3Full  out  1  R3 queue full
L1Overflow  out  1  sticky: L1 request dropped
R3Overflow  out  1  sticky: R3 request dropped
DoneTimeout  out  1  sticky: RODone timeout occurred

Behaviour:
- Clock and reset: single clock CLK; reset SoftResetB is synchronous, active-low.
- Reset values: all outputs 0, both queues empty, FSM in IDLE, counters 0.
- Reset mid-operation: abandons the readout in flight with no strobe, and drops all queued entries.
- Queues: two independent FIFOs of FIFO_DEPTH.
  - Full is evaluated on the registered state at the start of the cycle.
  - A request arriving while its queue is full is dropped and sets its Overflow flag, even if the same cycle pops.
  - Push and pop in the same cycle on a non-full queue are both honoured.
- FSM states: IDLE, STROBE, WAIT_DONE, GAP.
- IDLE:
  - No queue has an entry: stay.
  - Otherwise select a queue:
    - R3 is selected if non-empty, unless r3_run==R3_MAX_RUN and L1 is non-empty; then L1 is selected.
    - Otherwise L1 is selected.
  - Pop the head of the selected queue, load ROAddr and ROIsR3, go to STROBE.
  - A request that arrives in IDLE is eligible 1 cycle after push, since the queue is registered.
  - So request-to-strobe latency is 2 cycles minimum.
- STROBE:
  - ROReadStrob=1 and ROBusy=1 for exactly this cycle.
  - The cycle counter restarts at 0 here.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - ROBusy=1.
  - RODone → GAP.
  - DONE_TIMEOUT cycles without RODone → set DoneTimeout, go to GAP.
  - RODone outside WAIT_DONE is ignored.
- GAP:
  - ROBusy=0.
  - Remain until the counter reaches MIN_GAP-1 (counted from STROBE), then go to IDLE.
  - The next strobe is therefore never closer than MIN_GAP cycles.
- r3_run counter:
  - Increments on an R3 grant while L1 is non-empty.
  - Clears on an L1 grant, or whenever L1 is empty at grant time.
  - Saturates at R3_MAX_RUN.
- ROAddr and ROIsR3 hold their values until the next grant.
- Sticky flags: cleared by ClearFlags or reset. If ClearFlags and a set event occur in the same cycle, the set wins.
- Address arithmetic: ROAddr passes through unmodified, with no wrap logic. The L0ID value itself is produced upstream.

Decomposition:
- Shared package/include holds:
  - RO_ADDR_WIDTH (same macro as the readout logic);
  - FSM state encoding (2-bit, IDLE=0, STROBE=1, WAIT_DONE=2, GAP=3);
  - default MIN_GAP and FIFO_DEPTH constants.
- One sub-module, ro_req_fifo:
  - parameterised width/depth, synchronous;
  - push, pop, dout, empty, full.
  - It is instantiated twice (L1, R3).
- Arbitration and FSM stay in the top level.

Test Plan:
- Single L1Req with L1ID=0x12 at cycle 0, RODone at cycle 5 → ROReadStrob high only at cycle 2, ROAddr=0x12, ROIsR3=0, ROBusy high cycles 2–5, next strobe possible no earlier than cycle 6.
- L1Req (0x20) and R3Req (0x30) in the same cycle, RODone 1 cycle after each strobe → first strobe ROAddr=0x30 with ROIsR3=1, second strobe 0x20, strobes exactly 4 cycles apart.
- L1 queue holds 1 entry while 5 R3 requests are queued, RODone immediate each time → grant order R3,R3,R3,L1,R3,R3.
- 5 back-to-back L1Req (0x01–0x05) while a readout is stalled in WAIT_DONE → 0x05 dropped, L1Overflow=1 and stays 1 until ClearFlags; 0x01–0x04 read out in order.
- Strobe issued, RODone never asserted → DoneTimeout=1 after 255 cycles in WAIT_DONE; FSM proceeds to the next queued request.
- SoftResetB low for 1 cycle during WAIT_DONE with 2 entries queued → all outputs 0 next cycle; no further strobes without new requests.

Source files
------------

// File: rtl/ro_request_sequencer_pkg.sv
// Shared constants and FSM encoding for the readout request sequencer.
// Holds the L0ID/readout address width used by the readout logic, the default
// queue depth, strobe spacing, R3 run limit and done-timeout values, and the
// 2-bit sequencer state encoding.
package ro_request_sequencer_pkg;

    localparam int unsigned RO_ADDR_WIDTH_DEF = 8;
    localparam int unsigned FIFO_DEPTH_DEF    = 4;
    localparam int unsigned MIN_GAP_DEF       = 4;
    localparam int unsigned R3_MAX_RUN_DEF    = 3;
    localparam int unsigned DONE_TIMEOUT_DEF  = 255;

    // Shared STROBE-relative cycle counter, also used for the done timeout.
    localparam int unsigned CNT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STROBE    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } ro_state_e;

endpackage

// File: rtl/ro_req_fifo.sv
// Synchronous request queue holding L0IDs for one requester class.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   push, din    enqueue request (ignored when full)
//   pop          dequeue head (ignored when empty)
//   dout         current head entry
//   empty, full  registered occupancy flags
module ro_req_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    // Full/empty come from registered state, so a push while full is dropped
    // even if the same cycle pops.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Occupancy update
    always_comb begin
        count_d = count;
        case ({do_push, do_pop})
            2'b10:   count_d = count + CW'(1);
            2'b01:   count_d = count - CW'(1);
            default: count_d = count;
        endcase
    end

    // Pointers and flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_d;
            empty <= (count_d == '0);
            full  <= (count_d == CW'(DEPTH));
        end
    end

    // Storage (no reset needed; pointers define validity)
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ro_request_sequencer.sv
// Arbitrates L1 and R3 readout requests of the L0 buffer and sequences one
// readout at a time: strobe, wait for completion (with timeout), then enforce a
// minimum strobe-to-strobe gap before the next grant.
// Ports:
//   CLK, SoftResetB      clock, synchronous active-low reset
//   L1Req/L1ID           L1 readout request and its L0ID
//   R3Req/R3ID           R3 readout request and its L0ID
//   RODone               readout datapath finished (only honoured in WAIT_DONE)
//   ClearFlags           clears sticky flags (a same-cycle set wins)
//   ROReadStrob          one-cycle readout start
//   ROAddr/ROIsR3        address and class of current/last readout
//   ROBusy               high from strobe until readout complete
//   L1Full/R3Full        queue full
//   L1Overflow/R3Overflow/DoneTimeout  sticky error flags
module ro_request_sequencer
    import ro_request_sequencer_pkg::*;
#(
    parameter int unsigned RO_ADDR_WIDTH = RO_ADDR_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH    = FIFO_DEPTH_DEF,
    parameter int unsigned MIN_GAP       = MIN_GAP_DEF,
    parameter int unsigned R3_MAX_RUN    = R3_MAX_RUN_DEF,
    parameter int unsigned DONE_TIMEOUT  = DONE_TIMEOUT_DEF
) (
    input  logic                     CLK,
    input  logic                     SoftResetB,
    input  logic                     L1Req,
    input  logic [RO_ADDR_WIDTH-1:0] L1ID,
    input  logic                     R3Req,
    input  logic [RO_ADDR_WIDTH-1:0] R3ID,
    input  logic                     RODone,
    input  logic                     ClearFlags,
    output logic                     ROReadStrob,
    output logic [RO_ADDR_WIDTH-1:0] ROAddr,
    output logic                     ROIsR3,
    output logic                     ROBusy,
    output logic                     L1Full,
    output logic                     R3Full,
    output logic                     L1Overflow,
    output logic                     R3Overflow,
    output logic                     DoneTimeout
);

    localparam int unsigned RUN_WIDTH = $clog2(R3_MAX_RUN + 1);

    ro_state_e                state;
    ro_state_e                state_d;
    logic [CNT_WIDTH-1:0]     cnt;
    logic [CNT_WIDTH-1:0]     cnt_d;
    logic [RUN_WIDTH-1:0]     r3_run;
    logic [RUN_WIDTH-1:0]     run_d;
    logic [RO_ADDR_WIDTH-1:0] addr_d;
    logic                     is_r3_d;
    logic                     grant_en;
    logic                     pick_r3;
    logic                     timeout_hit;

    logic                     l1_empty;
    logic                     l1_full;
    logic                     l1_pop;
    logic [RO_ADDR_WIDTH-1:0] l1_head;
    logic                     r3_empty;
    logic                     r3_full;
    logic                     r3_pop;
    logic [RO_ADDR_WIDTH-1:0] r3_head;

    ro_req_fifo #(
        .WIDTH (RO_ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_l1_fifo (
        .clk   (CLK),
        .rst_n (SoftResetB),
        .push  (L1Req),
        .din   (L1ID),
        .pop   (l1_pop),
        .dout  (l1_head),
        .empty (l1_empty),
        .full  (l1_full)
    );

    ro_req_fifo #(
        .WIDTH (RO_ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_r3_fifo (
        .clk   (CLK),
        .rst_n (SoftResetB),
        .push  (R3Req),
        .din   (R3ID),
        .pop   (r3_pop),
        .dout  (r3_head),
        .empty (r3_empty),
        .full  (r3_full)
    );

    // Queue flags are registered inside the FIFOs
    assign L1Full = l1_full;
    assign R3Full = r3_full;

    // Next-state, arbitration and pop control
    always_comb begin
        state_d     = state;
        cnt_d       = (cnt == '1) ? cnt : cnt + CNT_WIDTH'(1);
        run_d       = r3_run;
        addr_d      = ROAddr;
        is_r3_d     = ROIsR3;
        l1_pop      = 1'b0;
        r3_pop      = 1'b0;
        grant_en    = 1'b0;
        pick_r3     = 1'b0;
        timeout_hit = 1'b0;

        case (state)
            ST_IDLE: grant_en = 1'b1;
            ST_STROBE: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (RODone) begin
                    state_d = ST_GAP;
                end else if (cnt >= CNT_WIDTH'(DONE_TIMEOUT)) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                // Leaving GAP grants in the same cycle, so back-to-back
                // strobes land exactly MIN_GAP cycles apart.
                if (cnt >= CNT_WIDTH'(MIN_GAP - 1)) begin
                    state_d  = ST_IDLE;
                    grant_en = 1'b1;
                end
            end
        endcase

        if (grant_en && (!l1_empty || !r3_empty)) begin
            // R3 has priority unless it has used up its run while L1 waits
            pick_r3 = !r3_empty && !((r3_run == RUN_WIDTH'(R3_MAX_RUN)) && !l1_empty);
            state_d = ST_STROBE;
            cnt_d   = '0;
            if (pick_r3) begin
                r3_pop  = 1'b1;
                addr_d  = r3_head;
                is_r3_d = 1'b1;
                if (l1_empty) begin
                    run_d = '0;
                end else if (r3_run != RUN_WIDTH'(R3_MAX_RUN)) begin
                    run_d = r3_run + RUN_WIDTH'(1);
                end
            end else begin
                l1_pop  = 1'b1;
                addr_d  = l1_head;
                is_r3_d = 1'b0;
                run_d   = '0;
            end
        end
    end

    // State register and registered outputs
    always_ff @(posedge CLK) begin
        if (!SoftResetB) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            r3_run      <= '0;
            ROReadStrob <= 1'b0;
            ROBusy      <= 1'b0;
            ROAddr      <= '0;
            ROIsR3      <= 1'b0;
            L1Overflow  <= 1'b0;
            R3Overflow  <= 1'b0;
            DoneTimeout <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            r3_run      <= run_d;
            ROReadStrob <= (state_d == ST_STROBE);
            ROBusy      <= (state_d == ST_STROBE) || (state_d == ST_WAIT_DONE);
            ROAddr      <= addr_d;
            ROIsR3      <= is_r3_d;
            // Sticky flags: a set event overrides a same-cycle clear
            L1Overflow  <= (L1Req && l1_full) || (L1Overflow && !ClearFlags);
            R3Overflow  <= (R3Req && r3_full) || (R3Overflow && !ClearFlags);
            DoneTimeout <= timeout_hit || (DoneTimeout && !ClearFlags);
        end
    end

endmodule
